// File: rtl/vram_pkg.sv
// Shared VRAM geometry, colour/address widths, fill FSM encoding and pixel address helper.
// Used by vram_fill_seq and vram_write_arbiter; see VRAM_WRITE_CLIP_EN in vram_fill_seq.
package vram_pkg;

  localparam int HSIZE   = 256;
  localparam int VSIZE   = 256;
  localparam int COORD_W = 8;
  localparam int COLOR_W = 3;
  localparam int ADDR_W  = $clog2(HSIZE * VSIZE);

  typedef enum logic [1:0] {
    FILL_IDLE = 2'd0,
    FILL_RUN  = 2'd1,
    FILL_DONE = 2'd2
  } fill_state_e;

  function automatic logic [ADDR_W-1:0] pix_addr(input logic [COORD_W-1:0] x,
                                                 input logic [COORD_W-1:0] y);
    return ADDR_W'(int'(y) * HSIZE + int'(x));
  endfunction

endpackage

// File: rtl/vram_fill_seq.sv
// Rectangle-fill sequencer: latches the rectangle, scans it row-major one pixel per grant.
// With VRAM_WRITE_CLIP_EN defined, pixels past the right/bottom edge are scanned but not requested.
module vram_fill_seq
  import vram_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [COORD_W-1:0] x0,
  input  logic [COORD_W-1:0] y0,
  input  logic [COORD_W:0]   w,
  input  logic [COORD_W:0]   h,
  input  logic [COLOR_W-1:0] color,
  input  logic               fill_grant,
  output logic               fill_req,
  output logic [COORD_W-1:0] px,
  output logic [COORD_W-1:0] py,
  output logic [COLOR_W-1:0] fill_color,
  output logic               busy,
  output logic               done
);

  fill_state_e        state_q, state_d;
  logic [COORD_W-1:0] x0_q, x0_d, y0_q, y0_d;
  logic [COORD_W-1:0] cx_q, cx_d, cy_q, cy_d;
  logic [COORD_W:0]   w_q, w_d, h_q, h_d;
  logic [COLOR_W-1:0] color_q, color_d;
  logic               busy_q, busy_d, done_q, done_d;
  logic               run, clip, step, last_x, last_y;

  assign run = (state_q == FILL_RUN);

`ifdef VRAM_WRITE_CLIP_EN
  logic [COORD_W:0] sum_x, sum_y;
  assign sum_x = {1'b0, x0_q} + {1'b0, cx_q};
  assign sum_y = {1'b0, y0_q} + {1'b0, cy_q};
  assign px    = sum_x[COORD_W-1:0];
  assign py    = sum_y[COORD_W-1:0];
  // A clipped pixel still costs one scan cycle, but never reaches the arbiter.
  assign clip  = run && (sum_x[COORD_W] || sum_y[COORD_W]);
`else
  assign px    = x0_q + cx_q;
  assign py    = y0_q + cy_q;
  assign clip  = 1'b0;
`endif

  assign fill_req   = run && !clip;
  assign step       = run && (fill_grant || clip);
  assign last_x     = ({1'b0, cx_q} == w_q - 1'b1);
  assign last_y     = ({1'b0, cy_q} == h_q - 1'b1);
  assign fill_color = color_q;
  assign busy       = busy_q;
  assign done       = done_q;

  always_comb begin
    // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latch).
    state_d = state_q;
    x0_d    = x0_q;
    y0_d    = y0_q;
    w_d     = w_q;
    h_d     = h_q;
    color_d = color_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    unique case (state_q)
      FILL_IDLE: begin
        if (start && !busy_q) begin
          x0_d    = x0;
          y0_d    = y0;
          w_d     = w;
          h_d     = h;
          color_d = color;
          cx_d    = '0;
          cy_d    = '0;
          state_d = (w == '0 || h == '0) ? FILL_DONE : FILL_RUN;
        end
      end
      FILL_RUN: begin
        if (step) begin
          if (last_x) begin
            cx_d = '0;
            if (last_y) state_d = FILL_DONE;
            else        cy_d    = cy_q + 1'b1;
          end else begin
            cx_d = cx_q + 1'b1;
          end
        end
      end
      FILL_DONE: state_d = FILL_IDLE;
      default:   state_d = FILL_IDLE;
    endcase
    // The done pulse trails the DONE state by a cycle; busy covers it so START stays locked out.
    busy_d = (state_d != FILL_IDLE) || (state_q == FILL_DONE);
    done_d = (state_q == FILL_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: sequential state uses <= so every flop samples pre-edge values.
      state_q <= FILL_IDLE;
      x0_q    <= '0;
      y0_q    <= '0;
      w_q     <= '0;
      h_q     <= '0;
      color_q <= '0;
      cx_q    <= '0;
      cy_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x0_q    <= x0_d;
      y0_q    <= y0_d;
      w_q     <= w_d;
      h_q     <= h_d;
      color_q <= color_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: rtl/vram_write_arbiter.sv
// Owns VRAM write port A: arbitrates CPU pixel writes against the fill engine, one registered write per cycle.
// Optional clipping of fill pixels is enabled by defining VRAM_WRITE_CLIP_EN.
module vram_write_arbiter
  import vram_pkg::*;
#(
  parameter int CPU_BURST_MAX = 4
) (
  input  logic               CLK,
  input  logic               I_RESET,
  input  logic               I_CPU_REQ,
  input  logic [COORD_W-1:0] I_CPU_X,
  input  logic [COORD_W-1:0] I_CPU_Y,
  input  logic [COLOR_W-1:0] I_CPU_COLOR,
  output logic               O_CPU_ACK,
  input  logic               I_FILL_START,
  input  logic [COORD_W-1:0] I_FILL_X0,
  input  logic [COORD_W-1:0] I_FILL_Y0,
  input  logic [COORD_W:0]   I_FILL_W,
  input  logic [COORD_W:0]   I_FILL_H,
  input  logic [COLOR_W-1:0] I_FILL_COLOR,
  output logic               O_FILL_BUSY,
  output logic               O_FILL_DONE,
  output logic               O_VRAM_WE,
  output logic [ADDR_W-1:0]  O_VRAM_ADDR,
  output logic [COLOR_W-1:0] O_VRAM_DIN
);

  localparam int                 BURST_W     = $clog2(CPU_BURST_MAX + 1);
  localparam logic [BURST_W-1:0] BURST_LIMIT = BURST_W'(CPU_BURST_MAX);

  logic               fill_req, fill_gnt, cpu_gnt, cpu_req_eff, force_fill;
  logic [COORD_W-1:0] fill_px, fill_py;
  logic [COLOR_W-1:0] fill_color;
  logic               we_q, we_d, ack_q, ack_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [COLOR_W-1:0] din_q, din_d;
  logic [BURST_W-1:0] burst_q, burst_d;

  vram_fill_seq u_fill_seq (
    .clk        (CLK),
    .rst        (I_RESET),
    .start      (I_FILL_START),
    .x0         (I_FILL_X0),
    .y0         (I_FILL_Y0),
    .w          (I_FILL_W),
    .h          (I_FILL_H),
    .color      (I_FILL_COLOR),
    .fill_grant (fill_gnt),
    .fill_req   (fill_req),
    .px         (fill_px),
    .py         (fill_py),
    .fill_color (fill_color),
    .busy       (O_FILL_BUSY),
    .done       (O_FILL_DONE)
  );

  // The request still high in its own ACK cycle belongs to the write just made.
  assign cpu_req_eff = I_CPU_REQ && !ack_q;
  assign force_fill  = cpu_req_eff && fill_req && (burst_q == BURST_LIMIT);
  assign cpu_gnt     = cpu_req_eff && !force_fill;
  assign fill_gnt    = fill_req && !cpu_gnt;

  always_comb begin
    burst_d = burst_q;
    if (!fill_req || force_fill) burst_d = '0;
    else if (cpu_gnt)            burst_d = burst_q + 1'b1;

    we_d   = cpu_gnt || fill_gnt;
    ack_d  = cpu_gnt;
    addr_d = addr_q;
    din_d  = din_q;
    if (cpu_gnt) begin
      addr_d = pix_addr(I_CPU_X, I_CPU_Y);
      din_d  = I_CPU_COLOR;
    end else if (fill_gnt) begin
      addr_d = pix_addr(fill_px, fill_py);
      din_d  = fill_color;
    end
  end

  always_ff @(posedge CLK) begin
    if (I_RESET) begin
      we_q    <= 1'b0;
      ack_q   <= 1'b0;
      addr_q  <= '0;
      din_q   <= '0;
      burst_q <= '0;
    end else begin
      we_q    <= we_d;
      ack_q   <= ack_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      burst_q <= burst_d;
    end
  end

  assign O_VRAM_WE   = we_q;
  assign O_CPU_ACK   = ack_q;
  assign O_VRAM_ADDR = addr_q;
  assign O_VRAM_DIN  = din_q;

endmodule

// File: tb/tb_vram_write_arbiter.sv
// Self-checking bench for vram_write_arbiter: directed timing steps plus randomized fills with CPU traffic.
// Expected fill writes come from a nested-loop rectangle model; honours VRAM_WRITE_CLIP_EN.
module tb_vram_write_arbiter;

  localparam int CPU_BURST_MAX = 4;
  localparam int RUN_LIMIT     = 3000;

  logic        CLK = 1'b0;
  logic        I_RESET;
  logic        I_CPU_REQ;
  logic [7:0]  I_CPU_X, I_CPU_Y;
  logic [2:0]  I_CPU_COLOR;
  logic        O_CPU_ACK;
  logic        I_FILL_START;
  logic [7:0]  I_FILL_X0, I_FILL_Y0;
  logic [8:0]  I_FILL_W, I_FILL_H;
  logic [2:0]  I_FILL_COLOR;
  logic        O_FILL_BUSY, O_FILL_DONE, O_VRAM_WE;
  logic [15:0] O_VRAM_ADDR;
  logic [2:0]  O_VRAM_DIN;

  int vectors     = 0;
  int miscompares = 0;
  int exp_q[$];  // expected fill writes: {colour, addr[15:0]}

  always #5 CLK = ~CLK;

  vram_write_arbiter #(.CPU_BURST_MAX(CPU_BURST_MAX)) dut (
    .CLK          (CLK),
    .I_RESET      (I_RESET),
    .I_CPU_REQ    (I_CPU_REQ),
    .I_CPU_X      (I_CPU_X),
    .I_CPU_Y      (I_CPU_Y),
    .I_CPU_COLOR  (I_CPU_COLOR),
    .O_CPU_ACK    (O_CPU_ACK),
    .I_FILL_START (I_FILL_START),
    .I_FILL_X0    (I_FILL_X0),
    .I_FILL_Y0    (I_FILL_Y0),
    .I_FILL_W     (I_FILL_W),
    .I_FILL_H     (I_FILL_H),
    .I_FILL_COLOR (I_FILL_COLOR),
    .O_FILL_BUSY  (O_FILL_BUSY),
    .O_FILL_DONE  (O_FILL_DONE),
    .O_VRAM_WE    (O_VRAM_WE),
    .O_VRAM_ADDR  (O_VRAM_ADDR),
    .O_VRAM_DIN   (O_VRAM_DIN)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Rectangle model: every pixel of the W x H box in row-major order.
  function automatic void build_fill(input int x0, input int y0, input int w, input int h, input int col);
    exp_q.delete();
    for (int j = 0; j < h; j++) begin
      for (int i = 0; i < w; i++) begin
        int x;
        int y;
        x = x0 + i;
        y = y0 + j;
`ifdef VRAM_WRITE_CLIP_EN
        if (x > 255 || y > 255) continue;
`endif
        exp_q.push_back((col << 16) | ((y % 256) * 256 + (x % 256)));
      end
    end
  endfunction

  task automatic set_fill(input int x0, input int y0, input int w, input int h, input int col);
    I_FILL_X0    = 8'(x0);
    I_FILL_Y0    = 8'(y0);
    I_FILL_W     = 9'(w);
    I_FILL_H     = 9'(h);
    I_FILL_COLOR = 3'(col);
  endtask

  // Runs one fill with random CPU traffic and scores every write against the models.
  task automatic run_fill(input string tag, input int x0, input int y0, input int w, input int h,
                          input int col, input int cpu_pct, input bit restart);
    bit cpu_pend = 1'b0;
    bit prev_ack = 1'b0;
    int cpu_addr = 0;
    int cpu_col  = 0;
    int cpu_run  = 0;
    int dones    = 0;
    int cyc      = 0;
    int e;
    build_fill(x0, y0, w, h, col);
    set_fill(x0, y0, w, h, col);
    I_FILL_START = 1'b1;
    while (cyc < RUN_LIMIT && !(dones != 0 && !cpu_pend)) begin
      tick();
      cyc++;
      I_FILL_START = 1'b0;
      if (restart && cyc == 2) begin
        I_FILL_START = 1'b1;
        set_fill(x0 + 37, y0 + 11, 1, 1, col ^ 7);
      end
      if (O_CPU_ACK) begin
        check({tag, "_ack_pending"}, 32'(cpu_pend), 32'd1);
        check({tag, "_ack_we"}, 32'(O_VRAM_WE), 32'd1);
        check({tag, "_cpu_addr"}, 32'(O_VRAM_ADDR), 32'(cpu_addr));
        check({tag, "_cpu_din"}, 32'(O_VRAM_DIN), 32'(cpu_col));
        check({tag, "_ack_spacing"}, 32'(prev_ack), 32'd0);
        cpu_pend = 1'b0;
        cpu_run++;
        if (exp_q.size() != 0)
          check({tag, "_cpu_burst"}, 32'(cpu_run <= CPU_BURST_MAX), 32'd1);
      end else if (O_VRAM_WE) begin
        if (exp_q.size() == 0) begin
          check({tag, "_extra_write"}, 32'(O_VRAM_WE), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check({tag, "_fill_addr"}, 32'(O_VRAM_ADDR), 32'(e & 32'hFFFF));
          check({tag, "_fill_din"}, 32'(O_VRAM_DIN), 32'(e >> 16));
        end
        cpu_run = 0;
      end
      prev_ack = O_CPU_ACK;
      if (O_FILL_DONE) dones++;
      if (!cpu_pend && dones == 0 && int'($urandom_range(99)) < cpu_pct) begin
        cpu_pend    = 1'b1;
        I_CPU_X     = 8'($urandom_range(255));
        I_CPU_Y     = 8'($urandom_range(255));
        I_CPU_COLOR = 3'($urandom_range(7));
        cpu_addr    = int'(I_CPU_Y) * 256 + int'(I_CPU_X);
        cpu_col     = int'(I_CPU_COLOR);
      end
      I_CPU_REQ = cpu_pend;
    end
    check({tag, "_finished"}, 32'(cyc < RUN_LIMIT), 32'd1);
    check({tag, "_fill_left"}, 32'(exp_q.size()), 32'd0);
    check({tag, "_done_count"}, 32'(dones), 32'd1);
    tick();
    check({tag, "_idle_we"}, 32'(O_VRAM_WE), 32'd0);
    check({tag, "_idle_busy"}, 32'(O_FILL_BUSY), 32'd0);
    check({tag, "_idle_done"}, 32'(O_FILL_DONE), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n;
    int k;
    int dones;
    I_RESET      = 1'b1;
    I_CPU_REQ    = 1'b0;
    I_CPU_X      = '0;
    I_CPU_Y      = '0;
    I_CPU_COLOR  = '0;
    I_FILL_START = 1'b0;
    set_fill(0, 0, 0, 0, 0);
    repeat (3) tick();
    check("rst_we", 32'(O_VRAM_WE), 32'd0);
    check("rst_addr", 32'(O_VRAM_ADDR), 32'd0);
    check("rst_din", 32'(O_VRAM_DIN), 32'd0);
    check("rst_ack", 32'(O_CPU_ACK), 32'd0);
    check("rst_busy", 32'(O_FILL_BUSY), 32'd0);
    check("rst_done", 32'(O_FILL_DONE), 32'd0);
    I_RESET = 1'b0;
    tick();

    // Single CPU write: registered one cycle after grant, ACK alongside.
    I_CPU_REQ = 1'b1; I_CPU_X = 8'd10; I_CPU_Y = 8'd20; I_CPU_COLOR = 3'd5;
    tick();
    check("cpu_we", 32'(O_VRAM_WE), 32'd1);
    check("cpu_addr", 32'(O_VRAM_ADDR), 32'h140A);
    check("cpu_din", 32'(O_VRAM_DIN), 32'd5);
    check("cpu_ack", 32'(O_CPU_ACK), 32'd1);
    I_CPU_REQ = 1'b0;
    tick();
    check("cpu_we_after", 32'(O_VRAM_WE), 32'd0);
    check("cpu_ack_after", 32'(O_CPU_ACK), 32'd0);
    check("cpu_addr_hold", 32'(O_VRAM_ADDR), 32'h140A);

    // REQ held high through ACK: the ACK cycle is skipped, next request served after.
    I_CPU_REQ = 1'b1; I_CPU_X = 8'd3; I_CPU_Y = 8'd1; I_CPU_COLOR = 3'd2;
    tick();
    check("hold_ack1", 32'(O_CPU_ACK), 32'd1);
    tick();
    check("hold_gap_we", 32'(O_VRAM_WE), 32'd0);
    tick();
    check("hold_ack2", 32'(O_CPU_ACK), 32'd1);
    check("hold_addr2", 32'(O_VRAM_ADDR), 32'h0103);
    I_CPU_REQ = 1'b0;
    tick();
    check("hold_end_we", 32'(O_VRAM_WE), 32'd0);

    // 3x2 fill with exact cycle timing.
    build_fill(4, 2, 3, 2, 6);
    set_fill(4, 2, 3, 2, 6);
    I_FILL_START = 1'b1;
    tick();
    I_FILL_START = 1'b0;
    check("fill_first_we", 32'(O_VRAM_WE), 32'd0);
    check("fill_busy", 32'(O_FILL_BUSY), 32'd1);
    for (int i = 0; i < 6; i++) begin
      tick();
      check("fill_we", 32'(O_VRAM_WE), 32'd1);
      check("fill_addr", 32'(O_VRAM_ADDR), 32'(exp_q[i] & 32'hFFFF));
      check("fill_din", 32'(O_VRAM_DIN), 32'(exp_q[i] >> 16));
      check("fill_done_early", 32'(O_FILL_DONE), 32'd0);
    end
    tick();
    check("fill_end_we", 32'(O_VRAM_WE), 32'd0);
    check("fill_done", 32'(O_FILL_DONE), 32'd1);
    check("fill_busy_at_done", 32'(O_FILL_BUSY), 32'd1);
    tick();
    check("fill_done_drop", 32'(O_FILL_DONE), 32'd0);
    check("fill_busy_drop", 32'(O_FILL_BUSY), 32'd0);

    // Zero-width rectangle: DONE two cycles after START, no writes.
    set_fill(9, 9, 0, 5, 1);
    I_FILL_START = 1'b1;
    tick();
    I_FILL_START = 1'b0;
    check("w0_busy", 32'(O_FILL_BUSY), 32'd1);
    check("w0_done_early", 32'(O_FILL_DONE), 32'd0);
    check("w0_we1", 32'(O_VRAM_WE), 32'd0);
    tick();
    check("w0_done", 32'(O_FILL_DONE), 32'd1);
    check("w0_we2", 32'(O_VRAM_WE), 32'd0);
    tick();
    check("w0_done_drop", 32'(O_FILL_DONE), 32'd0);
    check("w0_busy_drop", 32'(O_FILL_BUSY), 32'd0);

    // Edge wrap / clip, contention, and START while busy.
    run_fill("edge", 254, 0, 4, 1, 7, 0, 1'b0);
    run_fill("contend", 20, 30, 1, 8, 4, 100, 1'b0);
    run_fill("restart", 100, 50, 4, 2, 3, 0, 1'b1);

    // Reset in the middle of a 4x4 fill aborts it silently.
    set_fill(16, 16, 4, 4, 2);
    I_FILL_START = 1'b1;
    tick();
    I_FILL_START = 1'b0;
    n = 0;
    k = 0;
    while (n < 3 && k < 20) begin
      tick();
      k++;
      if (O_VRAM_WE) n++;
    end
    check("mid_writes", 32'(n), 32'd3);
    I_RESET = 1'b1;
    tick();
    I_RESET = 1'b0;
    check("mid_rst_we", 32'(O_VRAM_WE), 32'd0);
    check("mid_rst_addr", 32'(O_VRAM_ADDR), 32'd0);
    check("mid_rst_din", 32'(O_VRAM_DIN), 32'd0);
    check("mid_rst_ack", 32'(O_CPU_ACK), 32'd0);
    check("mid_rst_busy", 32'(O_FILL_BUSY), 32'd0);
    check("mid_rst_done", 32'(O_FILL_DONE), 32'd0);
    n = 0;
    dones = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (O_VRAM_WE) n++;
      if (O_FILL_DONE) dones++;
    end
    check("post_rst_writes", 32'(n), 32'd0);
    check("post_rst_dones", 32'(dones), 32'd0);
    run_fill("after_rst", 16, 16, 4, 4, 2, 30, 1'b0);

    // Randomized rectangles (some straddling the edges) under random CPU load.
    for (int t = 0; t < 10; t++) begin
      int rx, ry, rw, rh;
      rx = (t % 3 == 0) ? int'($urandom_range(255, 250)) : int'($urandom_range(255));
      ry = (t % 4 == 1) ? int'($urandom_range(255, 252)) : int'($urandom_range(255));
      rw = int'($urandom_range(6));
      rh = int'($urandom_range(5));
      run_fill("rand", rx, ry, rw, rh, int'($urandom_range(7)), int'($urandom_range(100)), 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/vram_write_arbiter.md
Name: vram_write_arbiter

Overview:
- Owns VRAM write port A; shares it between the CPU draw path (single-pixel writes) and an internal rectangle-fill engine.
- Issues at most one registered pixel write per cycle, addressed y*256+x.
- Sits between the core execute stage and the vram instance, replacing direct CPU drive of vram_we/vram_address/vram_in.

Parameters:
- HSIZE, 256, framebuffer width in pixels; power of two; address = y*HSIZE+x
- VSIZE, 256, framebuffer height in pixels
- CPU_BURST_MAX, 4, consecutive CPU grants allowed while a fill write is pending before fill must be granted

Ports:
- CLK  in  1  system clock
- I_RESET  in  1  synchronous active-high reset
- I_CPU_REQ  in  1  CPU pixel-write request; held until ack
- I_CPU_X  in  8  CPU pixel x
- I_CPU_Y  in  8  CPU pixel y
- I_CPU_COLOR  in  3  CPU pixel colour
- O_CPU_ACK  out  1  one-cycle pulse; write performed this cycle
- I_FILL_START  in  1  one-cycle start pulse
- I_FILL_X0  in  8  rectangle left
- I_FILL_Y0  in  8  rectangle top
- I_FILL_W  in  9  width 0..256
- I_FILL_H  in  9  height 0..256
- I_FILL_COLOR  in  3  fill colour
- O_FILL_BUSY  out  1  fill in progress
- O_FILL_DONE  out  1  one-cycle pulse at fill completion
- O_VRAM_WE  out  1  to vram wea
- O_VRAM_ADDR  out  16  to vram addra
- O_VRAM_DIN  out  3  to vram dina

Behaviour:
- Reset: all outputs 0; fill FSM IDLE; burst counter 0. A reset mid-fill aborts it with no DONE pulse.
- Fill FSM states: IDLE, RUN, DONE.
  - IDLE + START: latch X0/Y0/W/H/COLOR, set cx=0, cy=0, go to RUN.
  - If W==0 or H==0, go to DONE instead and perform no writes.
  - RUN: fill request is asserted.
  - On each fill grant, cx increments. When cx==W-1, cx resets to 0 and cy increments. Scan is row-major.
  - Grant of pixel (W-1,H-1) goes to DONE.
  - DONE: O_FILL_DONE=1 for one cycle, then IDLE.
  - O_FILL_BUSY=1 in RUN and DONE.
- START while BUSY is ignored and does not reload parameters.
- Fill pixel coordinates: px=(X0+cx) mod 256, py=(Y0+cy) mod 256. Address arithmetic uses 16-bit y*HSIZE+x.
- Arbitration is evaluated each cycle on the requests present in cycle N:
  - Default: CPU has priority.
  - If both request and burst counter == CPU_BURST_MAX, fill wins and the counter clears.
  - Counter increments on a CPU grant while fill requests, and clears on any cycle fill does not request.
- Latency: grant in cycle N. In cycle N+1, O_VRAM_WE=1 with the registered ADDR/DIN, and O_CPU_ACK pulses in the same cycle N+1 (CPU grants only).
- The CPU must hold REQ/X/Y/COLOR stable until ACK. REQ may drop the cycle after ACK.
- The CPU is not re-granted in cycle N+1 for the same request: REQ seen in the ACK cycle is ignored. Minimum CPU spacing is 2 cycles.
- No grant: O_VRAM_WE=0. ADDR/DIN hold their last value.
- Fill throughput with no CPU traffic: 1 pixel/cycle. DONE pulses 1 cycle after the final write cycle.

Optional Feature:
- VRAM_WRITE_CLIP_EN defined:
  - Fill pixels with X0+cx>255 or Y0+cy>255 are scanned but not written. They consume a cycle with O_VRAM_WE=0 and no grant.
  - CPU writes are unaffected.
- Undefined: coordinates wrap mod 256 as above, and all W*H pixels are written.

Decomposition:
- Shared package vram_pkg: HSIZE, VSIZE, colour width (3), VRAM address width (16), fill FSM state encoding constants.
- Sub-module vram_fill_seq: latches rectangle, runs cx/cy counters and FSM, and outputs fill_req/px/py/color/busy/done.
  - Advances on fill_grant.
  - Has a clip-skip input/behaviour under the macro.
- The arbiter, burst counter and output registers live in vram_write_arbiter.

Test Plan:
- CPU write: REQ, x=10, y=20, colour=5, no fill → cycle N+1: WE=1, ADDR=0x140A, DIN=5, ACK pulse; next cycle WE=0.
- Fill X0=4, Y0=2, W=3, H=2, colour=6, no CPU → 6 consecutive writes at 0x0204, 0x0205, 0x0206, 0x0304, 0x0305, 0x0306; DONE pulse once; BUSY drops after it.
- Contention: CPU REQ re-raised immediately after each ACK, plus fill 1x8 → at most 4 CPU grants between consecutive fill grants; all 8 fill pixels written; DONE asserted.
- W=0 start → DONE pulse 2 cycles after START, zero writes. START while BUSY → ignored, original rectangle completes unchanged.
- Edge fill X0=254, Y0=0, W=4, H=1: without macro → ADDR 0x00FE, 0x00FF, 0x0000, 0x0001. With VRAM_WRITE_CLIP_EN → only 0x00FE, 0x00FF written, DONE still pulses.
- I_RESET asserted mid-fill (after 3 of 16 pixels) → next cycle all outputs 0, BUSY=0, no DONE; a new START afterwards runs normally.
